// File: rtl/pipe_ctrl_n_pkg.sv
// Shared types and constants for the pipeline hazard/redirect controller.
// Holds the halt FSM encoding, the zero-address constant and the stall-vector width helper.
package pipe_ctrl_n_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } halt_state_e;

  localparam int MAX_ADDR_W = 64;
  localparam logic [MAX_ADDR_W-1:0] ZERO_ADDR = '0;

  // Stages 0..FLUSH_STAGES-1 are younger than the redirect source and get a NOP on flush.
  localparam int FLUSH_STAGES = 3;

  // Stall vector carries the PC hold bit plus one bit per stage register.
  function automatic int stall_w(input int nstage);
    return nstage + 1;
  endfunction

endpackage

// File: rtl/pipe_redirect_hold.sv
// Interrupt/jump redirect arbiter with a pending register; event is visible combinationally,
// and a redirect fetch cannot take yet (pc_ready_i=0) is held until pc_ready_i=1.
module pipe_redirect_hold
  import pipe_ctrl_n_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              int_assert_i,
  input  logic [ADDR_W-1:0] int_addr_i,
  input  logic              jump_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              pc_ready_i,
  output logic              flush_o,
  output logic              redirect_valid_o,
  output logic [ADDR_W-1:0] flush_addr_o
);

  logic              pend_vld_q, pend_vld_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              int_ev, jump_ev, ev, pend_vis;
  logic [ADDR_W-1:0] ev_addr;

  always_comb begin
    int_ev  = en_i & ~rst & int_assert_i;
    // A jump arriving behind a held redirect is on the wrong path.
    jump_ev = en_i & ~rst & jump_i & ~pend_vld_q;
    ev      = int_ev | jump_ev;
    ev_addr = int_ev ? int_addr_i : jump_addr_i;
    pend_vis = pend_vld_q & ~rst;

    pend_vld_d  = pend_vld_q;
    pend_addr_d = pend_addr_q;
    if (ev && !pc_ready_i) begin
      pend_vld_d  = 1'b1;
      pend_addr_d = ev_addr;
    end else if (pc_ready_i) begin
      pend_vld_d  = 1'b0;
      pend_addr_d = ZERO_ADDR[ADDR_W-1:0];
    end

    flush_o          = ev;
    redirect_valid_o = ev | pend_vis;
    if (ev) begin
      flush_addr_o = ev_addr;
    end else if (pend_vis) begin
      flush_addr_o = pend_addr_q;
    end else begin
      flush_addr_o = ZERO_ADDR[ADDR_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_vld_q  <= 1'b0;
      pend_addr_q <= ZERO_ADDR[ADDR_W-1:0];
    end else begin
      pend_vld_q  <= pend_vld_d;
      pend_addr_q <= pend_addr_d;
    end
  end

endmodule

// File: rtl/pipe_ctrl_n.sv
// NSTAGE pipeline stall/bubble/redirect controller with debug-halt drain FSM; stall is zero latency,
// redirects held until pc_ready_i. Optional per-stage stall counters under PIPE_CTRL_PERF_EN.
module pipe_ctrl_n
  import pipe_ctrl_n_pkg::*;
#(
  parameter int NSTAGE = 4,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef PIPE_CTRL_PERF_EN
  input  logic                    perf_clr_i,
  output logic [NSTAGE*CNT_W-1:0] perf_stall_cnt_o,
`endif
  input  logic [NSTAGE-1:0]       stallreq_i,
  input  logic [NSTAGE-1:0]       stage_valid_i,
  input  logic                    int_assert_i,
  input  logic [ADDR_W-1:0]       int_addr_i,
  input  logic                    jump_i,
  input  logic [ADDR_W-1:0]       jump_addr_i,
  input  logic                    pc_ready_i,
  input  logic                    haltreq_i,
  output logic [NSTAGE:0]         stall_o,
  output logic [NSTAGE-1:0]       bubble_o,
  output logic                    flush_o,
  output logic [ADDR_W-1:0]       flush_addr_o,
  output logic                    redirect_valid_o,
  output logic                    halted_o
);

  localparam int SW = stall_w(NSTAGE);

  halt_state_e   state_q, state_d, st;
  logic [SW-1:0] base_stall;
  logic          any_above;
  logic          redir_en;

  // State-driven outputs read as RUN while reset is held.
  assign st       = rst ? ST_RUN : state_q;
  assign redir_en = (st != ST_HALTED);
  assign halted_o = (st == ST_HALTED);

  pipe_redirect_hold #(
    .ADDR_W (ADDR_W)
  ) u_redirect (
    .clk              (clk),
    .rst              (rst),
    .en_i             (redir_en),
    .int_assert_i     (int_assert_i),
    .int_addr_i       (int_addr_i),
    .jump_i           (jump_i),
    .jump_addr_i      (jump_addr_i),
    .pc_ready_i       (pc_ready_i),
    .flush_o          (flush_o),
    .redirect_valid_o (redirect_valid_o),
    .flush_addr_o     (flush_addr_o)
  );

  always_comb begin
    base_stall = '0;
    any_above  = 1'b0;
    for (int k = NSTAGE - 1; k >= 0; k--) begin
      any_above       = any_above | stallreq_i[k];
      base_stall[k+1] = any_above;
    end
    base_stall[0] = any_above;
  end

  always_comb begin
    stall_o = base_stall;
    if (flush_o) stall_o[NSTAGE:1] = '0;
    if (st == ST_DRAIN) stall_o[0] = 1'b1;
    if (st == ST_HALTED) stall_o = '1;
    for (int k = 0; k < NSTAGE; k++) begin
      bubble_o[k] = (stall_o[k] & ~stall_o[k+1]) | (flush_o & (k < FLUSH_STAGES));
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (haltreq_i) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!haltreq_i) begin
          state_d = ST_RUN;
        end else if (stage_valid_i == '0 && !redirect_valid_o) begin
          state_d = ST_HALTED;
        end
      end
      ST_HALTED: if (!haltreq_i) state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [NSTAGE-1:0] top_hot;
  logic              perf_above;
  logic [CNT_W-1:0]  cnt_q [NSTAGE];
  logic [CNT_W-1:0]  cnt_d [NSTAGE];

  always_comb begin
    top_hot    = '0;
    perf_above = 1'b0;
    for (int k = NSTAGE - 1; k >= 0; k--) begin
      top_hot[k] = stallreq_i[k] & ~perf_above;
      perf_above = perf_above | stallreq_i[k];
    end
    for (int k = 0; k < NSTAGE; k++) begin
      cnt_d[k] = cnt_q[k];
      if (perf_clr_i) begin
        cnt_d[k] = '0;
      end else if (top_hot[k] && (cnt_q[k] != '1)) begin
        cnt_d[k] = cnt_q[k] + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NSTAGE; k++) begin
      if (rst) cnt_q[k] <= '0;
      else     cnt_q[k] <= cnt_d[k];
    end
  end

  always_comb begin
    for (int k = 0; k < NSTAGE; k++) begin
      perf_stall_cnt_o[k*CNT_W +: CNT_W] = cnt_q[k];
    end
  end
`else
  // CNT_W only sizes the counters, which this build omits.
  if (CNT_W < 1) begin : g_no_perf
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl_n.sv
// Directed bench for pipe_ctrl_n: stall/bubble table, redirect arbitration and hold,
// halt drain sequence, reset behaviour and, when PIPE_CTRL_PERF_EN is set, the stall counters.
module tb_pipe_ctrl_n;
  localparam int NSTAGE = 4;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NSTAGE-1:0] stallreq_i, stage_valid_i;
  logic              int_assert_i, jump_i, pc_ready_i, haltreq_i;
  logic [ADDR_W-1:0] int_addr_i, jump_addr_i;
  logic [NSTAGE:0]   stall_o;
  logic [NSTAGE-1:0] bubble_o;
  logic              flush_o, redirect_valid_o, halted_o;
  logic [ADDR_W-1:0] flush_addr_o;
`ifdef PIPE_CTRL_PERF_EN
  logic                    perf_clr_i;
  logic [NSTAGE*CNT_W-1:0] perf_stall_cnt_o;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_ctrl_n #(.NSTAGE(NSTAGE), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst              (rst),
`ifdef PIPE_CTRL_PERF_EN
    .perf_clr_i       (perf_clr_i),
    .perf_stall_cnt_o (perf_stall_cnt_o),
`endif
    .stallreq_i       (stallreq_i),
    .stage_valid_i    (stage_valid_i),
    .int_assert_i     (int_assert_i),
    .int_addr_i       (int_addr_i),
    .jump_i           (jump_i),
    .jump_addr_i      (jump_addr_i),
    .pc_ready_i       (pc_ready_i),
    .haltreq_i        (haltreq_i),
    .stall_o          (stall_o),
    .bubble_o         (bubble_o),
    .flush_o          (flush_o),
    .flush_addr_o     (flush_addr_o),
    .redirect_valid_o (redirect_valid_o),
    .halted_o         (halted_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; checks happen #4 later, mid-cycle.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [NSTAGE-1:0] req_tbl [4];
  logic [NSTAGE:0]   stall_tbl [4];
  logic [NSTAGE-1:0] bub_tbl [4];

  initial begin
    req_tbl[0] = 4'b0100; stall_tbl[0] = 5'b01111; bub_tbl[0] = 4'b1000;
    req_tbl[1] = 4'b0101; stall_tbl[1] = 5'b01111; bub_tbl[1] = 4'b1000;
    req_tbl[2] = 4'b0001; stall_tbl[2] = 5'b00011; bub_tbl[2] = 4'b0010;
    req_tbl[3] = 4'b1000; stall_tbl[3] = 5'b11111; bub_tbl[3] = 4'b0000;

    rst = 1'b1; stallreq_i = '0; stage_valid_i = '0; int_assert_i = 1'b0; jump_i = 1'b0;
    pc_ready_i = 1'b0; haltreq_i = 1'b0; int_addr_i = '0; jump_addr_i = '0;
`ifdef PIPE_CTRL_PERF_EN
    perf_clr_i = 1'b0;
`endif
    cyc(); cyc();
    rst = 1'b0; #4;
    check("rst_stall", stall_o, 0);
    check("rst_bubble", bubble_o, 0);
    check("rst_flush", flush_o, 0);
    check("rst_rv", redirect_valid_o, 0);
    check("rst_addr", flush_addr_o, 0);
    check("rst_halted", halted_o, 0);
    cyc();

    for (int i = 0; i < 4; i++) begin
      stallreq_i = req_tbl[i]; #4;
      check("stall_tbl", stall_o, stall_tbl[i]);
      check("bubble_tbl", bubble_o, bub_tbl[i]);
      cyc();
    end

    // Jump accepted immediately, with an EX stall that the flush overrides.
    stallreq_i = 4'b0100; jump_i = 1'b1; jump_addr_i = 32'h8000_0100; pc_ready_i = 1'b1; #4;
    check("jmp_flush", flush_o, 1);
    check("jmp_rv", redirect_valid_o, 1);
    check("jmp_addr", flush_addr_o, 32'h8000_0100);
    check("jmp_stall", stall_o, 5'b00001);
    check("jmp_bubble", bubble_o, 4'b0111);
    cyc();
    stallreq_i = '0; jump_i = 1'b0; #4;
    check("jmp_after_flush", flush_o, 0);
    check("jmp_after_rv", redirect_valid_o, 0);
    check("jmp_after_addr", flush_addr_o, 0);
    cyc();

    // Jump held while fetch is busy for three cycles.
    pc_ready_i = 1'b0; jump_i = 1'b1; #4;
    check("hold1_flush", flush_o, 1);
    check("hold1_addr", flush_addr_o, 32'h8000_0100);
    cyc();
    jump_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #4;
      check("holdn_flush", flush_o, 0);
      check("holdn_rv", redirect_valid_o, 1);
      check("holdn_addr", flush_addr_o, 32'h8000_0100);
      cyc();
    end
    pc_ready_i = 1'b1; #4;
    check("hold4_rv", redirect_valid_o, 1);
    check("hold4_addr", flush_addr_o, 32'h8000_0100);
    check("hold4_flush", flush_o, 0);
    cyc();
    #4;
    check("hold_clr_rv", redirect_valid_o, 0);
    cyc();

    // Interrupt beats a simultaneous jump.
    int_assert_i = 1'b1; int_addr_i = 32'h8000_0004; jump_i = 1'b1; jump_addr_i = 32'h8000_0100; #4;
    check("prio_addr", flush_addr_o, 32'h8000_0004);
    check("prio_flush", flush_o, 1);
    cyc();
    int_assert_i = 1'b0; jump_i = 1'b0;

    // Interrupt overwrites a pending jump; a later jump is ignored.
    pc_ready_i = 1'b0; jump_i = 1'b1; jump_addr_i = 32'h8000_0200; #4;
    check("pj_addr", flush_addr_o, 32'h8000_0200);
    cyc();
    jump_i = 1'b0; int_assert_i = 1'b1; #4;
    check("ovr_flush", flush_o, 1);
    check("ovr_addr", flush_addr_o, 32'h8000_0004);
    cyc();
    int_assert_i = 1'b0; jump_i = 1'b1; jump_addr_i = 32'h8000_0300; #4;
    check("ign_flush", flush_o, 0);
    check("ign_addr", flush_addr_o, 32'h8000_0004);
    cyc();
    jump_i = 1'b0; pc_ready_i = 1'b1; #4;
    check("ovr_rel_rv", redirect_valid_o, 1);
    check("ovr_rel_addr", flush_addr_o, 32'h8000_0004);
    cyc();
    #4;
    check("ovr_clr_rv", redirect_valid_o, 0);
    cyc();

    // Debug halt drains the pipeline.
    haltreq_i = 1'b1; stage_valid_i = 4'b1111; #4;
    check("halt_req_stall", stall_o, 0);
    cyc();
    stage_valid_i = 4'b0110; #4;
    check("drain_stall", stall_o, 5'b00001);
    check("drain_halted", halted_o, 0);
    cyc();
    stage_valid_i = 4'b0000; #4;
    check("drain2_halted", halted_o, 0);
    cyc();
    jump_i = 1'b1; #4;
    check("halted", halted_o, 1);
    check("halted_stall", stall_o, 5'b11111);
    check("halted_rv", redirect_valid_o, 0);
    check("halted_flush", flush_o, 0);
    cyc();
    jump_i = 1'b0; haltreq_i = 1'b0; #4;
    check("unhalt_same", halted_o, 1);
    cyc();
    #4;
    check("unhalt_next", halted_o, 0);
    check("unhalt_stall", stall_o, 0);
    cyc();

    // Reset drops a pending redirect.
    pc_ready_i = 1'b0; jump_i = 1'b1; jump_addr_i = 32'h8000_0400; #4;
    check("pre_rst_rv", redirect_valid_o, 1);
    cyc();
    jump_i = 1'b0; rst = 1'b1;
    cyc();
    rst = 1'b0; #4;
    check("post_rst_rv", redirect_valid_o, 0);
    check("post_rst_addr", flush_addr_o, 0);
    cyc();

    // Reset from HALTED returns to RUN.
    haltreq_i = 1'b1;
    cyc(); cyc(); #4;
    check("halt_again", halted_o, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0; haltreq_i = 1'b0; #4;
    check("rst_halt_halted", halted_o, 0);
    check("rst_halt_stall", stall_o, 0);

`ifdef PIPE_CTRL_PERF_EN
    stallreq_i = 4'b0100;
    repeat (5) cyc();
    stallreq_i = '0; #4;
    check("perf_ex5", perf_stall_cnt_o[2*CNT_W +: CNT_W], 5);
    check("perf_id0", perf_stall_cnt_o[1*CNT_W +: CNT_W], 0);
    cyc();
    stallreq_i = 4'b0100; perf_clr_i = 1'b1;
    cyc();
    stallreq_i = '0; perf_clr_i = 1'b0; #4;
    check("perf_clr", perf_stall_cnt_o[2*CNT_W +: CNT_W], 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
